// File: rtl/run_ctl_pkg.sv
// run_ctl_pkg: definitions shared by the run-command issuer and the INIT/RUNNING
// run-state FSMs that it drives.
//   run_op_e            host command opcode: STOP targets INIT, START targets RUNNING
//   RUN_INIT/RUN_RUNNING encoding of the downstream run-state bit
//   run_issuer_state_e  issuer FSM states
//   op_target()         maps an opcode to the run state it should produce
package run_ctl_pkg;

  typedef enum logic {OP_STOP = 1'b0, OP_START = 1'b1} run_op_e;

  localparam logic RUN_INIT    = 1'b0;
  localparam logic RUN_RUNNING = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } run_issuer_state_e;

  function automatic logic op_target(input run_op_e op);
    return (op == OP_START) ? RUN_RUNNING : RUN_INIT;
  endfunction

endpackage

// File: rtl/run_cmd_issuer.sv
// run_cmd_issuer: turns host START/STOP commands into start_o/stop_o pulses for
// a downstream INIT/RUNNING FSM and confirms the move by watching run_state_i.
// A pulse that gets no response within TIMEOUT_CYCLES is re-issued, up to
// MAX_RETRY times; after that the command ends with an err pulse.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_op               0=STOP (target INIT), 1=START (target RUNNING)
//   run_state_i          downstream state, 0=INIT 1=RUNNING
//   start_o, stop_o      downstream in0/in1 pulses
//   busy                 high whenever not IDLE
//   done, err            one-cycle completion / failure pulses
//   err_sticky, err_clr  latched failure flag and its clear
//   attempts             pulses issued for the current/last command
module run_cmd_issuer
  import run_ctl_pkg::*;
#(
  parameter int PULSE_LEN      = 1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 3,
  localparam int AW            = $clog2(MAX_RETRY + 2)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic          run_state_i,
  output logic          start_o,
  output logic          stop_o,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          err_sticky,
  input  logic          err_clr,
  output logic [AW-1:0] attempts
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] ATT_MAX    = AW'(MAX_RETRY + 1);

  run_issuer_state_e state_q, state_d;
  run_op_e           op_q, op_d;
  logic [PW-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [AW-1:0]     att_q, att_d;
  logic              sticky_q, sticky_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      op_q        <= OP_STOP;
      pulse_cnt_q <= '0;
      wait_cnt_q  <= '0;
      att_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pulse_cnt_q <= pulse_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      att_q       <= att_d;
      sticky_q    <= sticky_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pulse_cnt_d = pulse_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    att_d       = att_q;
    sticky_d    = sticky_q;

    if (err_clr) sticky_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d        = run_op_e'(cmd_op);
          att_d       = '0;
          pulse_cnt_d = '0;
          // Already in the target state: confirm without touching the FSM.
          if (run_state_i == op_target(run_op_e'(cmd_op))) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PULSE;
            att_d   = AW'(1);
          end
        end
      end
      // A match seen here is ignored; the pulse always runs its full length
      // and the first WAIT cycle does the confirming.
      S_PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end
      S_WAIT: begin
        if (run_state_i == op_target(op_q)) begin
          state_d = S_DONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          if (att_q == ATT_MAX) begin
            state_d = S_ERR;
          end else begin
            state_d     = S_PULSE;
            att_d       = att_q + AW'(1);
            pulse_cnt_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        state_d  = S_IDLE;
        sticky_d = 1'b1;  // overrides a simultaneous err_clr
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign start_o    = (state_q == S_PULSE) && (op_q == OP_START);
  assign stop_o     = (state_q == S_PULSE) && (op_q == OP_STOP);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign err_sticky = sticky_q;
  assign attempts   = att_q;

endmodule

// File: tb/tb_run_cmd_issuer.sv
module tb_run_cmd_issuer;

  localparam int P  = 1;
  localparam int T  = 16;
  localparam int M  = 3;
  localparam int AW = $clog2(M + 2);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic          run_state_i = 1'b0;
  logic          start_o, stop_o, busy, done, err, err_sticky;
  logic          err_clr = 1'b0;
  logic [AW-1:0] attempts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_cmd_issuer #(.PULSE_LEN(P), .TIMEOUT_CYCLES(T), .MAX_RETRY(M)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .run_state_i(run_state_i), .start_o(start_o),
    .stop_o(stop_o), .busy(busy), .done(done), .err(err),
    .err_sticky(err_sticky), .err_clr(err_clr), .attempts(attempts)
  );

  // One command against a behavioural downstream FSM that ignores the first
  // `ign` pulses (or all of them when deaf) and otherwise moves to the
  // commanded state at once. Expected timing is computed from the protocol
  // rules: attempt i pulses at cycle 1+i*(T+P); confirmation comes one cycle
  // after the first WAIT cycle that sees the target; failure after M+1 full
  // attempts. Returns at the negedge of the done/err cycle.
  task automatic run_cmd(input logic op, input logic init_state, input int ign,
                         input bit deaf, input bit hold, input string nm);
    int  k, exp_end, exp_att, seen, end_c, pulse_cycles;
    bit  exp_err, got_err, fin, prev;
    int  rises[$];
    @(negedge clk);
    run_state_i = init_state;
    if (init_state == op) begin
      k = 0; exp_err = 0; exp_end = 1; exp_att = 0;
    end else if (!deaf && ign <= M) begin
      k = ign + 1; exp_err = 0; exp_end = 1 + (k - 1) * (T + P) + P + 1; exp_att = k;
    end else begin
      k = M + 1; exp_err = 1; exp_end = 1 + k * (T + P); exp_att = k;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before_accept got %b want 1", nm, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op;
    @(posedge clk);
    seen = 0; end_c = -1; got_err = 0; fin = 0; prev = 0; pulse_cycles = 0;
    for (int c = 1; c <= exp_end + 5 && !fin; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = hold; cmd_op = ~op;
      end
      checks++;
      if (start_o && stop_o) begin
        errors++; $display("FAIL %s both_pulses cycle %0d", nm, c);
      end
      if (start_o || stop_o) begin
        pulse_cycles++;
        if (!prev) rises.push_back(c);
        checks++;
        if (start_o !== op) begin
          errors++; $display("FAIL %s pulse_polarity cycle %0d start %b stop %b op %b", nm, c, start_o, stop_o, op);
        end
        if (!deaf && seen >= ign) run_state_i = op;
        seen++;
      end
      prev = start_o | stop_o;
      if (done || err) begin
        fin = 1; end_c = c; got_err = err;
      end
    end
    checks++;
    if (end_c !== exp_end) begin
      errors++; $display("FAIL %s end_cycle got %0d want %0d", nm, end_c, exp_end);
    end
    checks++;
    if (got_err !== exp_err) begin
      errors++; $display("FAIL %s outcome err got %b want %b", nm, got_err, exp_err);
    end
    checks++;
    if (pulse_cycles != k * P || rises.size() != k) begin
      errors++; $display("FAIL %s pulse_count got %0d rises %0d want %0d", nm, pulse_cycles, rises.size(), k);
    end
    for (int i = 0; i < rises.size() && i < k; i++) begin
      checks++;
      if (rises[i] != 1 + i * (T + P)) begin
        errors++; $display("FAIL %s pulse%0d_cycle got %0d want %0d", nm, i, rises[i], 1 + i * (T + P));
      end
    end
    checks++;
    if (attempts !== AW'(exp_att) || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL %s end_state attempts %0d want %0d busy %b ready %b", nm, attempts, exp_att, busy, cmd_ready);
    end
    if (hold) cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 1'b0; err_clr = 1'b0; run_state_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, start_o, stop_o, busy, done, err, err_sticky} !== 7'b1000000 || attempts !== '0) begin
      errors++; $display("FAIL reset outputs got %b attempts %0d want 1000000/0",
                         {cmd_ready, start_o, stop_o, busy, done, err, err_sticky}, attempts);
    end
    rstn = 1'b1;
  endtask

  task automatic test_start_basic();
    run_cmd(1'b1, 1'b0, 0, 0, 0, "start_basic");
  endtask

  task automatic test_already_running();
    run_cmd(1'b1, 1'b1, 0, 0, 0, "already_running");
  endtask

  task automatic test_retry();
    run_cmd(1'b1, 1'b0, 1, 0, 0, "retry_once");
    run_cmd(1'b0, 1'b1, 2, 0, 0, "stop_retry_twice");
  endtask

  task automatic test_exhaust();
    run_cmd(1'b1, 1'b0, 0, 1, 0, "exhaust");
    @(negedge clk);
    checks++;
    if (err_sticky !== 1'b1 || cmd_ready !== 1'b1 || err !== 1'b0 || attempts !== AW'(M + 1)) begin
      errors++; $display("FAIL exhaust_after sticky %b ready %b err %b attempts %0d want 1 1 0 %0d",
                         err_sticky, cmd_ready, err, attempts, M + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    @(negedge clk);
    run_state_i = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b1;
    @(posedge clk);
    // Third WAIT cycle of attempt 2.
    for (int c = 1; c <= 1 + (T + P) + P + 2; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || attempts !== AW'(2) || start_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_pre busy %b attempts %0d start %b want 1 2 0", busy, attempts, start_o);
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, start_o, stop_o, busy, done, err, err_sticky} !== 7'b1000000 || attempts !== '0) begin
      errors++; $display("FAIL reset_mid outputs got %b attempts %0d want 1000000/0",
                         {cmd_ready, start_o, stop_o, busy, done, err, err_sticky}, attempts);
    end
    rstn = 1'b1;
    bad = 0;
    for (int c = 0; c < 2 * T; c++) begin
      @(negedge clk);
      if (done || err || busy || start_o || stop_o) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reset_mid_quiet got activity want none");
    end
  endtask

  task automatic test_err_clr();
    run_cmd(1'b0, 1'b1, 0, 1, 1, "err_clr_hold");
    err_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++; $display("FAIL err_clr_same_cycle sticky got %b want 1", err_sticky);
    end
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_sticky !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL err_clr_next sticky %b busy %b want 0 0", err_sticky, busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, M + 1)),
              ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), "random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_start_basic();
    test_already_running();
    test_retry();
    test_exhaust();
    test_reset_mid();
    test_err_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
